// File: rtl/sram_ctrl_defs.sv
// Shared definitions for the single-port SRAM request controller.
// Controller state encoding and address width helper.
package sram_ctrl_defs;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Response FIFO with a registered head word and empty flag.
// Capacity is DEPTH words; the caller guarantees no push when full.
module sram_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q;
    logic             pop_ok;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop_i & valid_q;
    assign rdata_o = head_q;
    assign empty_o = ~valid_q;

    // Next head word: bypass the pushed word when it becomes the head
    always_comb begin
        cnt_d  = cnt_q + CW'(push_i) - CW'(pop_ok);
        rptr_d = pop_ok ? wrap_inc(rptr_q) : rptr_q;
        head_d = head_q;
        if (cnt_d != '0) begin
            if (cnt_q == '0 || (pop_ok && cnt_q == CW'(1)))
                head_d = wdata_i;
            else
                head_d = mem_q[rptr_d];
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push_i) wptr_q <= wrap_inc(wptr_q);
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= (cnt_d != '0);
        end
    end

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Valid/ready request front end for a 1-cycle-latency single-port SRAM.
// Optional power-on fill sweep enabled by SRAM_CTRL_INIT_EN.
module sram_1rw_req_ctrl
    import sram_ctrl_defs::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DATA_DEPTH = 1024,
    parameter int                    RSP_DEPTH  = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    ADDR_WIDTH = addr_bits(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dataw,
    input  logic [DATA_WIDTH-1:0] sram_datar,
    output logic                  init_done
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

    logic          run;
    logic          rd_acc;
    logic          rsp_pop;
    logic          fifo_empty;
    logic          infl_q;
    logic [CW-1:0] cred_q, cred_d;

    // Reads stall on credits only; writes flow whenever running
    assign req_ready = run & (req_we | (cred_q < CRED_MAX));
    assign rd_acc    = req_valid & req_ready & ~req_we;
    assign rsp_valid = ~fifo_empty;
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign cred_d    = cred_q + CW'(rd_acc) - CW'(rsp_pop);

    // Credits cover in-flight plus queued reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cred_q <= '0;
            infl_q <= 1'b0;
        end else begin
            cred_q <= cred_d;
            infl_q <= rd_acc;
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (infl_q),
        .wdata_i (sram_datar),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_rdata),
        .empty_o (fifo_empty)
    );

`ifdef SRAM_CTRL_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    ctrl_state_t           state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;

    // Fill sweep: one INIT_VALUE write per cycle, then hand over to RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            if (init_cnt_q == LAST_ADDR) begin
                state_q    <= ST_RUN;
                init_cnt_q <= '0;
            end else begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
        end
    end

    assign run        = (state_q == ST_RUN);
    assign init_done  = run;
    assign sram_ce    = run ? (req_valid & req_ready) : 1'b1;
    assign sram_we    = run ? req_we : 1'b1;
    assign sram_addr  = run ? req_addr : init_cnt_q;
    assign sram_dataw = run ? req_wdata : INIT_VALUE;
`else
    logic live_q;
    logic unused_init;

    // Hold requests off until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    assign unused_init = ^INIT_VALUE;
    assign run         = live_q;
    assign init_done   = 1'b1;
    assign sram_ce     = req_valid & req_ready;
    assign sram_we     = req_we;
    assign sram_addr   = req_addr;
    assign sram_dataw  = req_wdata;
`endif

endmodule
